onehot_encoder_rv: RTL

- Converts an unsigned binary position value into a one-hot vector {B,A} split across two LEN-wide halves.
- It is the inverse of the datapath's one-hot-to-binary decoder, and both use the same {B,A} bit ordering.
- Input and output are both READY-VALID interfaces, with a 2-entry skid buffer so the block can accept one transfer per cycle under backpressure.
- Sits between an ALU result stage and any consumer that needs one-hot operands.

---
 rtl/onehot_encoder_rv_pkg.sv | 22 ++
 rtl/onehot_encode_comb.sv | 29 ++
 rtl/onehot_encoder_rv.sv | 120 ++++++++++++
 3 files changed

// File: rtl/onehot_encoder_rv_pkg.sv
// Shared definitions for the one-hot encoder with ready/valid skid buffer.
package onehot_encoder_rv_pkg;

    // Skid-buffer occupancy state. Bit 0 set means main holds a word and
    // bit 1 set means skid holds a word too; 2'b10 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b01,
        S_FULL  = 2'b11
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LEN   = 8;

    // Width of the full {B,A} one-hot vector for a given half width.
    function automatic int oh_width(input int len);
        return 2 * len;
    endfunction

    localparam int OH_W = oh_width(DEF_LEN);

endpackage

// File: rtl/onehot_encode_comb.sv
// Combinational binary-to-one-hot encoder producing {B,A} plus a range error.
module onehot_encode_comb
    import onehot_encoder_rv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN   = DEF_LEN
) (
    input  logic [WIDTH-1:0]          i_Y,
    output logic [oh_width(LEN)-1:0]  o_oh,
    output logic                      o_err
);

    localparam int OHW = oh_width(LEN);

    // Compare at 32 bits so the range check stays unsigned and width-clean
    // for any WIDTH; when 2^WIDTH <= OHW the error term folds to zero.
    logic [31:0] y_w;

    // One-hot decode of the position; positions past the vector give all-zero plus error.
    always_comb begin
        y_w   = 32'(i_Y);
        o_oh  = '0;
        o_err = (y_w >= 32'(OHW));
        for (int i = 0; i < OHW; i++) begin
            o_oh[i] = (y_w == 32'(i));
        end
    end

endmodule

// File: rtl/onehot_encoder_rv.sv
// Binary position to split one-hot {B,A} encoder with a 2-entry skid buffer
// on a ready/valid interface, sustaining one word per cycle under backpressure.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_EMPTY | no word held; o_VALID=0, o_READY=1
// S_ONE   | main holds the output word; o_VALID=1, o_READY=1
// S_FULL  | main and skid both hold words; o_VALID=1, o_READY=0
module onehot_encoder_rv
    import onehot_encoder_rv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN   = DEF_LEN
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_Y,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [LEN-1:0]   o_A_OH,
    output logic [LEN-1:0]   o_B_OH,
    output logic             o_ERR
);

    localparam int OHW = oh_width(LEN);

    logic [OHW-1:0] enc_oh;
    logic           enc_err;
    logic [LEN-1:0] enc_a;
    logic [LEN-1:0] enc_b;

    state_t         state;
    logic [LEN-1:0] main_a;
    logic [LEN-1:0] main_b;
    logic           main_err;
    logic [LEN-1:0] skid_a;
    logic [LEN-1:0] skid_b;
    logic           skid_err;

    logic           in_fire;
    logic           out_fire;

    onehot_encode_comb #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_encode (
        .i_Y   (i_Y),
        .o_oh  (enc_oh),
        .o_err (enc_err)
    );

    assign enc_a = enc_oh[LEN-1:0];
    assign enc_b = enc_oh[OHW-1:LEN];

    // Handshake flags are decoded from registered state only, so neither
    // side sees a combinational path through the other's ready/valid.
    assign o_VALID  = (state != S_EMPTY);
    assign o_READY  = (state != S_FULL);
    assign in_fire  = i_VALID & o_READY;
    assign out_fire = o_VALID & i_READY;

    assign o_A_OH = main_a;
    assign o_B_OH = main_b;
    assign o_ERR  = main_err;

    // Skid-buffer FSM: main register drives the outputs, skid absorbs the
    // one extra word accepted in the cycle the consumer stalls.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state    <= S_EMPTY;
            main_a   <= '0;
            main_b   <= '0;
            main_err <= 1'b0;
            skid_a   <= '0;
            skid_b   <= '0;
            skid_err <= 1'b0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_a   <= enc_a;
                        main_b   <= enc_b;
                        main_err <= enc_err;
                        state    <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_a   <= enc_a;
                        main_b   <= enc_b;
                        main_err <= enc_err;
                    end else if (in_fire) begin
                        skid_a   <= enc_a;
                        skid_b   <= enc_b;
                        skid_err <= enc_err;
                        state    <= S_FULL;
                    end else if (out_fire) begin
                        // Main keeps its stale word; it is not sampled while empty.
                        state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // o_READY is low here, so only the drain side can fire.
                    if (out_fire) begin
                        main_a   <= skid_a;
                        main_b   <= skid_b;
                        main_err <= skid_err;
                        state    <= S_ONE;
                    end
                end
                default: begin
                    state <= S_EMPTY;
                end
            endcase
        end
    end

endmodule
